// File: rtl/bc_compactor_pipe.sv
// Pipelined bubble-collapsing compactor: kept lanes slide down past dropped lanes,
// one log-shifter stage per bit of the per-lane drop count.

module bc_compact_lane #(
  parameter int ELW = 33,
  parameter int DW  = 29,
  parameter int BIT = 0
) (
  input  logic           clk,
  input  logic [ELW-1:0] stay,
  input  logic [ELW-1:0] move,
  output logic [ELW-1:0] nxt
);
  // element layout: {keep, z, mt, lifm}; z starts at bit DW
  logic take_move, take_stay;

  assign take_move = move[ELW-1] && move[DW+BIT];
  assign take_stay = stay[ELW-1] && !stay[DW+BIT];
  assign nxt       = take_move ? move : (take_stay ? stay : '0);

  // LSB-first shifting never lands two kept elements on one lane
  assert property (@(posedge clk) !(take_move && take_stay));
endmodule

module bc_compactor_pipe #(
  parameter int NUMEL      = 8,
  parameter int NUMEL_LOG  = 3,
  parameter int WORD_WIDTH = 8,
  parameter int MT_WIDTH   = 21
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        i_valid,
  output logic                        i_ready,
  input  logic [NUMEL-1:0]            i_mask,
  input  logic [NUMEL*WORD_WIDTH-1:0] i_lifm,
  input  logic [NUMEL*MT_WIDTH-1:0]   i_mt,
  input  logic                        i_last,
  output logic                        o_valid,
  input  logic                        o_ready,
  output logic [NUMEL*WORD_WIDTH-1:0] o_lifm,
  output logic [NUMEL*MT_WIDTH-1:0]   o_mt,
  output logic [NUMEL-1:0]            o_mask,
  output logic [NUMEL_LOG:0]          o_count,
  output logic                        o_last
);
  localparam int ZW     = NUMEL_LOG;
  localparam int DW     = WORD_WIDTH + MT_WIDTH;
  localparam int ELW    = DW + ZW + 1;
  localparam int CW     = NUMEL_LOG + 1;
  localparam int STAGES = NUMEL_LOG;

  typedef logic [NUMEL-1:0][ELW-1:0] line_t;

  logic            en;
  logic [STAGES:0] vld_pipe;
  logic [STAGES:0] last_pipe;
  line_t           el_q  [STAGES:0];
  line_t           el_nx [STAGES:1];
  logic [CW-1:0]   cnt_q [STAGES:0];
  line_t           el_in;
  logic [CW-1:0]   cnt_in;
  logic [ZW-1:0]   z_run;
  logic            unused_tags;

  assign en      = !vld_pipe[STAGES] || o_ready;
  assign i_ready = en;

  // z_run counts dropped lanes below k; dropped lanes enter as all-zero elements
  always_comb begin
    el_in  = '0;
    cnt_in = '0;
    z_run  = '0;
    for (int k = 0; k < NUMEL; k++) begin
      if (i_mask[k]) begin
        el_in[k] = {1'b1, z_run, i_mt[k*MT_WIDTH +: MT_WIDTH], i_lifm[k*WORD_WIDTH +: WORD_WIDTH]};
        cnt_in   = cnt_in + 1'b1;
      end else begin
        z_run    = z_run + 1'b1;
      end
    end
  end

  for (genvar s = 1; s <= STAGES; s++) begin : g_stage
    localparam int SH = 1 << (s-1);
    line_t nx;
    for (genvar k = 0; k < NUMEL; k++) begin : g_lane
      logic [ELW-1:0] mv_el;
      if (k + SH < NUMEL) begin : g_mv
        assign mv_el = el_q[s-1][k+SH];
      end else begin : g_nomv
        assign mv_el = '0;
      end
      bc_compact_lane #(.ELW(ELW), .DW(DW), .BIT(s-1)) u_lane (
        .clk  (clk),
        .stay (el_q[s-1][k]),
        .move (mv_el),
        .nxt  (nx[k])
      );
    end
    assign el_nx[s] = nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      for (int s = 0; s <= STAGES; s++) begin
        el_q[s]  <= '0;
        cnt_q[s] <= '0;
      end
    end else if (en) begin
      vld_pipe  <= {vld_pipe[STAGES-1:0], i_valid};
      last_pipe <= {last_pipe[STAGES-1:0], i_valid && i_last};
      el_q[0]   <= i_valid ? el_in : '0;
      cnt_q[0]  <= i_valid ? cnt_in : '0;
      for (int s = 1; s <= STAGES; s++) begin
        el_q[s]  <= el_nx[s];
        cnt_q[s] <= cnt_q[s-1];
      end
    end
  end

  assign o_valid = vld_pipe[STAGES];
  assign o_last  = last_pipe[STAGES];
  assign o_count = cnt_q[STAGES];

  always_comb begin
    o_lifm      = '0;
    o_mt        = '0;
    o_mask      = '0;
    unused_tags = 1'b0;
    for (int k = 0; k < NUMEL; k++) begin
      o_lifm[k*WORD_WIDTH +: WORD_WIDTH] = el_q[STAGES][k][WORD_WIDTH-1:0];
      o_mt[k*MT_WIDTH +: MT_WIDTH]       = el_q[STAGES][k][WORD_WIDTH +: MT_WIDTH];
      o_mask[k]                          = (CW'(k) < cnt_q[STAGES]);
      unused_tags                        = unused_tags ^ (^el_q[STAGES][k][ELW-1:DW]);
    end
  end
endmodule

// File: doc/bc_compactor_pipe.md
Name: bc_compactor_pipe

Overview:
- Pipelined, parametrised bubble-collapsing compactor.
- Takes one line per beat:
  - NUMEL lifm words;
  - NUMEL matching metadata (mt) words;
  - a keep mask.
- Moves every kept lane to index (lane − number of dropped lanes below it), preserving order. Lanes above the kept count are zero-filled.
- Sits between the redundancy mask generator and the compressed-line buffer, with valid/ready on both sides.

Parameters:
- NUMEL, 8, lanes per line (power of two, ≥2)
- NUMEL_LOG, 3, log2(NUMEL)
- WORD_WIDTH, 8, lifm word width
- MT_WIDTH, 21, metadata word width (DIST_WIDTH*MAX_LIFM_RSIZ)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- i_valid  in  1  input beat valid
- i_ready  out  1  block can accept beat
- i_mask  in  NUMEL  bit k=1 keeps lane k
- i_lifm  in  NUMEL*WORD_WIDTH  lane k at [k*WORD_WIDTH +: WORD_WIDTH]
- i_mt  in  NUMEL*MT_WIDTH  lane k at [k*MT_WIDTH +: MT_WIDTH]
- i_last  in  1  last line of tile, passed through
- o_valid  out  1  output beat valid
- o_ready  in  1  downstream accepts
- o_lifm  out  NUMEL*WORD_WIDTH  compacted lifm
- o_mt  out  NUMEL*MT_WIDTH  compacted metadata
- o_mask  out  NUMEL  thermometer: low o_count bits set
- o_count  out  NUMEL_LOG+1  number of kept lanes (0..NUMEL)
- o_last  out  1  delayed i_last

Behaviour:
- Reset (async, reset_n=0):
  - all stage valid bits and data registers clear;
  - o_valid=0, o_lifm=0, o_mt=0, o_mask=0, o_count=0, o_last=0;
  - i_ready=1 on first cycle after release.
- Pipeline: NUMEL_LOG+1 register stages; latency = NUMEL_LOG+1 cycles from input handshake to o_valid when not stalled.
- Stage 0, on i_valid&&i_ready:
  - register lanes;
  - for each lane compute z_k = popcount(~i_mask[k-1:0]) (z_0=0), NUMEL_LOG bits;
  - zero data of dropped lanes and tag each lane with keep bit and z_k;
  - o_count value = popcount(i_mask).
- Stage s (s=1..NUMEL_LOG), shift by 2^(s-1):
  - a kept element with bit (s-1) of its z set moves down 2^(s-1) lanes, else stays;
  - z travels with the element;
  - destination lane takes the moving element if any, else the staying one, else zero/not-kept;
  - bits processed LSB first; no two kept elements ever collide (verification asserts this).
- Final stage drives o_lifm/o_mt from registers.
  - o_mask[k] = (k < o_count).
  - Lanes ≥ o_count are zero in both o_lifm and o_mt.
- Flow control:
  - global advance en = !o_valid || o_ready; all stages shift together when en=1;
  - i_ready = en (combinational from o_ready and o_valid);
  - bubbles (stage valid=0) advance like data; a bubble in the final stage with en=1 clears o_valid.
  - With o_ready=0 and o_valid=1, all stage registers and outputs hold stable; i_ready=0.
- Throughput: one line per cycle with o_ready held 1.
- Boundary cases:
  - i_mask all 1: output equals input, o_count=NUMEL, o_mask all 1.
  - i_mask all 0: o_lifm=o_mt=0, o_count=0, o_mask=0; beat still emitted with o_valid.
  - o_last is always the i_last of the same beat.
  - Reset asserted mid-stream discards all in-flight beats, with no partial output after release.
- o_valid must not depend combinationally on o_ready.

Test Plan:
- NUMEL=8, lifm lanes 0..7 = 0x10..0x17, mask=8'b1010_0110, o_ready=1 → after 4 cycles o_lifm lanes 0..3 = 0x11,0x12,0x15,0x17; lanes 4..7 = 0; o_count=4; o_mask=8'h0F; o_mt lanes permuted identically.
- mask=8'hFF, then 8'h00, then 8'h80, back-to-back with o_ready=1:
  - counts 8, 0, 1 on consecutive cycles 4, 5, 6;
  - third beat has lane0 = input lane7, all other lanes zero.
- 10 random beats streamed while o_ready is held 0 from cycle 2 to 7:
  - i_ready=0 whenever o_valid && !o_ready;
  - outputs stable while stalled;
  - all 10 beats emerge in order, none lost or duplicated, each matching the reference compaction model.
- i_last=1 on beat 3 of 5 → o_last=1 only on output beat 3.
- Assert reset_n=0 while 3 beats are in flight → o_valid=0 immediately; after release no stale beat appears and the next input emerges with latency 4.
- Random mask/data for 10k beats with random o_ready → scoreboard matches; internal collision assertion never fires.
